// File: rtl/pau_issue_ctrl_pkg.sv
// Shared types for the PAU requester: op/result payloads, issue-state enum, defaults.
// fu_data_t, TRANS_ID_BITS and xlen_t stand in for the core's shared definitions.
package pau_issue_ctrl_pkg;
  localparam int unsigned TIMEOUT_DEF   = 64;
  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef logic [XLEN-1:0]          xlen_t;
  typedef logic [TRANS_ID_BITS-1:0] trans_id_t;

  typedef enum logic [1:0] {PADD, PSUB, PMUL, PDIV} pau_op_e;

  typedef struct packed {
    pau_op_e   op;
    xlen_t     operand_a;
    xlen_t     operand_b;
    trans_id_t trans_id;
  } fu_data_t;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} issue_state_e;

  typedef struct packed {
    trans_id_t trans_id;
    xlen_t     result;
  } res_entry_t;
endpackage

// File: rtl/pau_issue_ctrl_if.sv
// Issue / PAU / writeback handshake bundle. master = requester, slave = its neighbours.
interface pau_issue_ctrl_if;
  import pau_issue_ctrl_pkg::*;
  logic      req_valid;
  logic      req_ready;
  fu_data_t  req_data;
  fu_data_t  pau_data;
  logic      pau_valid;
  logic      pau_ready;
  logic      pau_res_valid;
  trans_id_t pau_trans_id;
  xlen_t     pau_result;
  logic      wb_valid;
  logic      wb_ready;
  trans_id_t wb_trans_id;
  xlen_t     wb_result;

  modport master (
    input  req_valid, req_data, pau_ready, pau_res_valid, pau_trans_id, pau_result, wb_ready,
    output req_ready, pau_data, pau_valid, wb_valid, wb_trans_id, wb_result
  );
  modport slave (
    output req_valid, req_data, pau_ready, pau_res_valid, pau_trans_id, pau_result, wb_ready,
    input  req_ready, pau_data, pau_valid, wb_valid, wb_trans_id, wb_result
  );
endinterface

// File: rtl/pau_issue_ctrl_fifo.sv
// Generic synchronous FIFO with flush. Head reads as zero while empty so
// downstream buses idle at 0. Push while full is taken only with a same-cycle pop.
module pau_issue_ctrl_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? T'('0) : mem[rptr_q];

  // pointer/occupancy update; pointers wrap explicitly so any DEPTH works
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage write; contents need no reset, empty_o masks stale entries
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr_q] <= data_i;
  end
endmodule

// File: rtl/pau_issue_ctrl.sv
// PAU requester: queues ops from issue, keeps one op in flight to the PAU,
// catches the unbackpressured result pulse and offers it to writeback.
module pau_issue_ctrl
  import pau_issue_ctrl_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 2,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  pau_issue_ctrl_if.master    bus,
  output logic                busy_o,
  output logic                err_timeout_o,
  output logic                err_tag_o
);
  localparam int unsigned   CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  issue_state_e  state_q, state_d;
  fu_data_t      req_head;
  res_entry_t    res_in, res_head;
  trans_id_t     tag_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_full, req_empty, res_full, res_empty;
  logic          req_push, pau_valid, issue, res_push, res_pop, tag_bad;
  logic          err_to_q, err_tag_q;

  assign req_push = bus.req_valid && !req_full && !flush_i;
  assign issue    = pau_valid && bus.pau_ready;
  assign res_pop  = bus.wb_ready && !res_empty;
  assign res_in   = '{trans_id: tag_q, result: bus.pau_result};

  pau_issue_ctrl_fifo #(.T(fu_data_t), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i, .rst_i, .flush_i,
    .push_i(req_push), .data_i(bus.req_data), .pop_i(issue), .data_o(req_head),
    .full_o(req_full), .empty_o(req_empty)
  );

  // buffered results survive a flush: they belong to ops that already completed
  pau_issue_ctrl_fifo #(.T(res_entry_t), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_i, .rst_i, .flush_i(1'b0),
    .push_i(res_push), .data_i(res_in), .pop_i(bus.wb_ready), .data_o(res_head),
    .full_o(res_full), .empty_o(res_empty)
  );

  // issue state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake decode; a pulse coinciding with flush in WAIT
  // completes the op normally (the result was already produced)
  always_comb begin
    state_d   = state_q;
    pau_valid = 1'b0;
    res_push  = 1'b0;
    tag_bad   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // issue only with a result slot reserved, so the pulse can never be lost
        pau_valid = !req_empty && !res_full && !flush_i;
        if (pau_valid && bus.pau_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.pau_res_valid) begin
          res_push = 1'b1;
          tag_bad  = (bus.pau_trans_id != tag_q);
          state_d  = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (bus.pau_res_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in-flight timer: restarts on issue, counts while not IDLE, saturates at TIMEOUT
  always_comb begin
    cnt_d = cnt_q;
    if (issue)                                cnt_d = '0;
    else if (state_q != IDLE && cnt_q != TMO) cnt_d = cnt_q + 1'b1;
  end

  // in-flight tag, timer and sticky error flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q     <= '0;
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
      err_tag_q <= 1'b0;
    end else begin
      if (issue) tag_q <= req_head.trans_id;
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_q || (cnt_d == TMO);
      err_tag_q <= err_tag_q || tag_bad;
    end
  end

  // the free-slot gate on issue makes result overflow impossible
  assert property (@(posedge clk_i) disable iff (rst_i) !(res_push && res_full && !res_pop));

  assign bus.req_ready   = !req_full;
  assign bus.pau_valid   = pau_valid;
  assign bus.pau_data    = req_head;
  assign bus.wb_valid    = !res_empty;
  assign bus.wb_trans_id = res_head.trans_id;
  assign bus.wb_result   = res_head.result;
  assign busy_o          = !req_empty || (state_q != IDLE) || !res_empty;
  assign err_timeout_o   = err_to_q;
  assign err_tag_o       = err_tag_q;
endmodule

// File: tb/tb_pau_issue_ctrl.sv
// Bench for pau_issue_ctrl: directed scenarios, then randomized traffic against a
// transaction-level model (op queue, result queue, one in-flight op).
module tb_pau_issue_ctrl;
  import pau_issue_ctrl_pkg::*;
  localparam int REQ_DEPTH = 4;
  localparam int RES_DEPTH = 2;

  logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic busy_o, err_timeout_o, err_tag_o;
  int   total = 0, bad = 0;

  pau_issue_ctrl_if bus ();

  pau_issue_ctrl #(.REQ_DEPTH(REQ_DEPTH), .RES_DEPTH(RES_DEPTH), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .bus(bus),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_tag_o(err_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i           = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_data      = '0;
    bus.pau_ready     = 1'b0;
    bus.pau_res_valid = 1'b0;
    bus.pau_trans_id  = '0;
    bus.pau_result    = '0;
    bus.wb_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  function automatic fu_data_t mk_op(input int tag, input xlen_t a);
    fu_data_t d;
    d.op        = PADD;
    d.operand_a = a;
    d.operand_b = ~a;
    d.trans_id  = trans_id_t'(tag);
    return d;
  endfunction

  task automatic push_op(input int tag);
    bus.req_valid = 1'b1;
    bus.req_data  = mk_op(tag, xlen_t'(64'h100 + tag));
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse(input int tag, input xlen_t r);
    bus.pau_res_valid = 1'b1;
    bus.pau_trans_id  = trans_id_t'(tag);
    bus.pau_result    = r;
    tick();
    bus.pau_res_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_pau_valid"}, bus.pau_valid, 0);
    chk({tag, "_pau_data"},  bus.pau_data.operand_a, 0);
    chk({tag, "_wb_valid"},  bus.wb_valid, 0);
    chk({tag, "_wb_tag"},    bus.wb_trans_id, 0);
    chk({tag, "_wb_res"},    bus.wb_result, 0);
    chk({tag, "_busy"},      busy_o, 0);
    chk({tag, "_err_to"},    err_timeout_o, 0);
    chk({tag, "_err_tag"},   err_tag_o, 0);
  endtask

  // randomized-phase model state
  fu_data_t   q[$];
  res_entry_t wbq[$];
  fu_data_t   cur;
  res_entry_t e;
  bit         inflight, drained, exp_pv, push_ok, issue;
  int         resp_cnt;

  initial begin
    // reset values
    do_reset();
    rst_i = 1'b1;
    #1;
    chk_reset_vals("rst");
    rst_i = 1'b0;

    // single op round trip
    do_reset();
    bus.pau_ready = 1'b1;
    push_op(3);
    chk("t1_pau_valid", bus.pau_valid, 1);
    chk("t1_pau_tag", bus.pau_data.trans_id, 3);
    tick();
    chk("t1_wait_pv", bus.pau_valid, 0);
    chk("t1_busy", busy_o, 1);
    tick();
    pulse(3, 64'h4000);
    chk("t1_wb_valid", bus.wb_valid, 1);
    chk("t1_wb_tag", bus.wb_trans_id, 3);
    chk("t1_wb_res", bus.wb_result, 64'h4000);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("t1_wb_done", bus.wb_valid, 0);
    chk("t1_idle_busy", busy_o, 0);

    // result buffer full blocks issue
    do_reset();
    bus.pau_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_op(i);
    pulse(0, 64'h10);
    chk("t2_pv_after0", bus.pau_valid, 1);
    chk("t2_pau_tag1", bus.pau_data.trans_id, 1);
    tick();
    pulse(1, 64'h11);
    chk("t2_pv_blocked", bus.pau_valid, 0);
    chk("t2_wb_tag0", bus.wb_trans_id, 0);
    tick();
    chk("t2_pv_held", bus.pau_valid, 0);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("t2_pv_freed", bus.pau_valid, 1);
    chk("t2_pau_tag2", bus.pau_data.trans_id, 2);
    chk("t2_wb_tag1", bus.wb_trans_id, 1);

    // push with simultaneous pop, fill, wrap, ordering 0..4
    do_reset();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_op(i);
    chk("t3_stall_tag", bus.pau_data.trans_id, 0);
    bus.req_valid = 1'b1;
    bus.req_data  = mk_op(3, 64'h103);
    bus.pau_ready = 1'b1;
    chk("t3_ready_pre", bus.req_ready, 1);
    tick();
    bus.pau_ready = 1'b0;
    chk("t3_ready_post", bus.req_ready, 1);
    bus.req_data = mk_op(4, 64'h104);
    tick();
    bus.req_valid = 1'b0;
    chk("t3_full", bus.req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      pulse(i, xlen_t'(64'h20 + i));
      chk($sformatf("t3_wb_tag%0d", i), bus.wb_trans_id, i);
      chk($sformatf("t3_wb_res%0d", i), bus.wb_result, 64'h20 + i);
      if (i < 4) begin
        chk($sformatf("t3_pau_tag%0d", i + 1), bus.pau_data.trans_id, i + 1);
        chk($sformatf("t3_pau_opa%0d", i + 1), bus.pau_data.operand_a, 64'h101 + i);
        bus.pau_ready = 1'b1;
      end
      tick();
      bus.pau_ready = 1'b0;
    end
    chk("t3_busy_end", busy_o, 0);

    // flush while in flight: result discarded, queue emptied
    do_reset();
    bus.pau_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_op(i);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_pv", bus.pau_valid, 0);
    chk("t4_ready", bus.req_ready, 1);
    chk("t4_busy_drain", busy_o, 1);
    pulse(0, 64'h55);
    chk("t4_wb_none", bus.wb_valid, 0);
    chk("t4_busy_end", busy_o, 0);
    tick();
    chk("t4_wb_none2", bus.wb_valid, 0);

    // timeout and tag mismatch
    do_reset();
    bus.pau_ready = 1'b1;
    push_op(2);
    tick();
    bus.pau_ready = 1'b0;
    repeat (63) tick();
    chk("t5_to_63", err_timeout_o, 0);
    tick();
    chk("t5_to_64", err_timeout_o, 1);
    pulse(5, 64'h77);
    chk("t5_err_tag", err_tag_o, 1);
    chk("t5_wb_tag", bus.wb_trans_id, 2);
    chk("t5_to_sticky", err_timeout_o, 1);

    // reset in WAIT with a buffered result
    do_reset();
    bus.pau_ready = 1'b1;
    push_op(1);
    tick();
    pulse(1, 64'h11);
    push_op(2);
    tick();
    chk("t6_pre_wb", bus.wb_valid, 1);
    rst_i = 1'b1;
    tick();
    chk_reset_vals("t6");
    rst_i = 1'b0;
    pulse(2, 64'h22);
    chk("t6_late_wb", bus.wb_valid, 0);
    chk("t6_late_busy", busy_o, 0);

    // randomized traffic against the transaction model
    do_reset();
    inflight = 0;
    drained  = 0;
    resp_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush_i           = ($urandom_range(0, 19) == 0);
      bus.req_valid     = ($urandom_range(0, 9) < 6);
      bus.req_data.op        = pau_op_e'($urandom_range(0, 3));
      bus.req_data.operand_a = {$urandom, $urandom};
      bus.req_data.operand_b = {$urandom, $urandom};
      bus.req_data.trans_id  = trans_id_t'($urandom_range(0, 7));
      bus.pau_ready     = ($urandom_range(0, 9) < 7);
      bus.wb_ready      = ($urandom_range(0, 1) == 1);
      bus.pau_res_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.pau_res_valid = 1'b1;
          bus.pau_trans_id  = cur.trans_id;
          bus.pau_result    = cur.operand_a ^ cur.operand_b;
        end
      end else if (!inflight && $urandom_range(0, 15) == 0) begin
        bus.pau_res_valid = 1'b1;
        bus.pau_trans_id  = trans_id_t'($urandom_range(0, 7));
        bus.pau_result    = {$urandom, $urandom};
      end
      #1;
      exp_pv = !inflight && q.size() > 0 && wbq.size() < RES_DEPTH && !flush_i;
      chk("r_pau_valid", bus.pau_valid, exp_pv);
      if (exp_pv) begin
        chk("r_pau_tag", bus.pau_data.trans_id, q[0].trans_id);
        chk("r_pau_opa", bus.pau_data.operand_a, q[0].operand_a);
      end
      chk("r_req_ready", bus.req_ready, q.size() < REQ_DEPTH);
      chk("r_wb_valid", bus.wb_valid, wbq.size() > 0);
      if (wbq.size() > 0) begin
        chk("r_wb_tag", bus.wb_trans_id, wbq[0].trans_id);
        chk("r_wb_res", bus.wb_result, wbq[0].result);
      end
      chk("r_busy", busy_o, q.size() > 0 || inflight || wbq.size() > 0);
      push_ok = bus.req_valid && !flush_i && q.size() < REQ_DEPTH;
      issue   = exp_pv && bus.pau_ready;
      if (bus.wb_ready && wbq.size() > 0) void'(wbq.pop_front());
      if (bus.pau_res_valid && inflight) begin
        if (!drained) begin
          e.trans_id = cur.trans_id;
          e.result   = cur.operand_a ^ cur.operand_b;
          wbq.push_back(e);
        end
        inflight = 0;
      end else if (flush_i && inflight) begin
        drained = 1;
      end
      if (flush_i) q.delete();
      if (issue) begin
        cur      = q.pop_front();
        inflight = 1;
        drained  = 0;
        resp_cnt = $urandom_range(1, 4);
      end
      if (push_ok) q.push_back(bus.req_data);
      tick();
    end
    chk("r_err_tag", err_tag_o, 0);
    chk("r_err_to", err_timeout_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
